// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: reads back an 8-digit hex seven-segment display from a strobed
// segment bus, rebuilds the 32-bit word and publishes it once it has been stable.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_in       segment pattern {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW=1
//   dig_sel      digit index of seg_in; digit i maps to data_out[4i+3:4i]
//   seg_strobe   seg_in/dig_sel valid this cycle
//   data_out     last published word
//   data_valid   1-cycle pulse when data_out is updated
//   data_stable  data_out matches the most recent valid frame
//   frame_err    1-cycle pulse: completed frame had an undecodable digit
//   timeout      1-cycle pulse: partial frame dropped after idle timeout
module seg7_frame_decoder #(
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYC    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [2:0]  dig_sel,
    input  logic        seg_strobe,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        data_stable,
    output logic        frame_err,
    output logic        timeout
);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

    logic [6:0]    seg;
    logic [3:0]    nib;
    logic          nib_ok;
    logic [31:0]   nib_buf, buf_next, frame_reg, last_frame;
    logic [7:0]    mask, mask_next;
    logic          bad, frame_bad, frame_done, same;
    logic [MW-1:0] match_cnt, cnt_next;
    logic [TW-1:0] idle_cnt;

    assign seg = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    // Undecodable digits are stored as 0 and only flagged through bad.
    assign buf_next  = (nib_buf & ~(32'hF << {dig_sel, 2'b00})) | ({28'd0, nib} << {dig_sel, 2'b00});
    assign mask_next = mask | (8'd1 << dig_sel);
    assign same      = frame_reg == last_frame;
    assign cnt_next  = !same ? MW'(1) : (match_cnt == MATCH_MAX ? MATCH_MAX : match_cnt + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            data_stable <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            nib_buf     <= '0;
            frame_reg   <= '0;
            last_frame  <= '0;
            mask        <= '0;
            bad         <= 1'b0;
            frame_bad   <= 1'b0;
            frame_done  <= 1'b0;
            match_cnt   <= '0;
            idle_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            frame_done <= 1'b0;
            if (seg_strobe) begin
                idle_cnt <= '0;
                nib_buf  <= buf_next;
                if (&mask_next) begin
                    frame_reg  <= buf_next;
                    frame_bad  <= bad | ~nib_ok;
                    frame_done <= 1'b1;
                    mask       <= '0;
                    bad        <= 1'b0;
                end else begin
                    mask <= mask_next;
                    bad  <= bad | ~nib_ok;
                end
            end else if (mask != '0) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt    <= '0;
                    mask        <= '0;
                    bad         <= 1'b0;
                    match_cnt   <= '0;
                    data_stable <= 1'b0;
                    timeout     <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
            // A frame completes with mask cleared, so evaluation never coincides with a timeout.
            if (frame_done) begin
                if (frame_bad) begin
                    frame_err   <= 1'b1;
                    match_cnt   <= '0;
                    data_stable <= 1'b0;
                end else begin
                    last_frame <= frame_reg;
                    match_cnt  <= cnt_next;
                    if (cnt_next == MATCH_MAX && !(data_stable && same)) begin
                        data_out    <= frame_reg;
                        data_valid  <= 1'b1;
                        data_stable <= 1'b1;
                    end else if (!same) begin
                        data_stable <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb_seg7_frame_decoder: directed checks of an active-high and an active-low decoder in lockstep.
module tb_seg7_frame_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [6:0]  seg_inv;
    logic [2:0]  dig_sel = '0;
    logic        seg_strobe = 1'b0;
    logic [31:0] data_out_a, data_out_b;
    logic        valid_a, valid_b, stable_a, stable_b, err_a, err_b, to_a, to_b;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [7:0][2:0] SEQ = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0] MIX = {3'd3, 3'd4, 3'd1, 3'd6, 3'd2, 3'd5, 3'd0, 3'd7};
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    assign seg_inv = ~seg_in;
    always #5 clk = ~clk;

    seg7_frame_decoder #(.STABLE_FRAMES(2), .TIMEOUT_CYC(16), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .seg_strobe(seg_strobe),
        .data_out(data_out_a), .data_valid(valid_a), .data_stable(stable_a),
        .frame_err(err_a), .timeout(to_a)
    );

    seg7_frame_decoder #(.STABLE_FRAMES(2), .TIMEOUT_CYC(16), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_inv), .dig_sel(dig_sel), .seg_strobe(seg_strobe),
        .data_out(data_out_b), .data_valid(valid_b), .data_stable(stable_b),
        .frame_err(err_b), .timeout(to_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [31:0] o,
                              input logic s, input logic e, input logic t);
        check({tag, ".a.valid"},  {31'd0, valid_a},  {31'd0, v});
        check({tag, ".a.out"},    data_out_a,        o);
        check({tag, ".a.stable"}, {31'd0, stable_a}, {31'd0, s});
        check({tag, ".a.err"},    {31'd0, err_a},    {31'd0, e});
        check({tag, ".a.to"},     {31'd0, to_a},     {31'd0, t});
        check({tag, ".b.valid"},  {31'd0, valid_b},  {31'd0, v});
        check({tag, ".b.out"},    data_out_b,        o);
        check({tag, ".b.stable"}, {31'd0, stable_b}, {31'd0, s});
        check({tag, ".b.err"},    {31'd0, err_b},    {31'd0, e});
        check({tag, ".b.to"},     {31'd0, to_b},     {31'd0, t});
    endtask

    task automatic send(input logic [2:0] d, input logic [6:0] p);
        seg_in     = p;
        dig_sel    = d;
        seg_strobe = 1'b1;
        @(negedge clk);
        seg_strobe = 1'b0;
    endtask

    // Returns just after the evaluation edge that follows the completing strobe.
    task automatic send_frame(input logic [31:0] w, input logic [7:0][2:0] ord);
        for (int i = 0; i < 8; i++) send(ord[i], seg_tab[w[4*ord[i] +: 4]]);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(32'h12345678, SEQ);
        check_outs("t1.f1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h12345678, SEQ);
        check_outs("t1.f2", 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("t1.pulse_end", 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0);
        send_frame(32'h12345678, SEQ);
        check_outs("t1.f3", 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0);

        send_frame(32'hCAFEF00D, MIX);
        check_outs("t2.f1", 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        send_frame(32'hCAFEF00D, MIX);
        check_outs("t2.f2", 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);

        send_frame(32'h12345678, SEQ);
        send_frame(32'h12345678, SEQ);
        check_outs("t3.restable", 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(3'(i), i == 3 ? 7'h00 : seg_tab[4'(8 - i)]);
        @(negedge clk);
        check_outs("t3.bad", 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_outs("t3.err_end", 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        send_frame(32'h12345678, SEQ);
        check_outs("t3.g1", 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        send_frame(32'h12345678, SEQ);
        check_outs("t3.g2", 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);

        send_frame(32'hDEADBEEF, SEQ);
        check_outs("t4.f1", 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        send_frame(32'hDEADBEEF, MIX);
        check_outs("t4.f2", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);

        // Partial frame carrying an undecodable digit must vanish with the timeout.
        send(3'd0, seg_tab[1]);
        send(3'd1, seg_tab[2]);
        send(3'd2, 7'h00);
        send(3'd3, seg_tab[4]);
        begin
            logic early = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                early |= to_a | to_b;
            end
            check("t5.no_early_timeout", {31'd0, early}, 32'd0);
        end
        @(negedge clk);
        check_outs("t5.timeout", 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("t5.to_end", 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0F1E2D3C, MIX);
        check_outs("t5.f1", 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0F1E2D3C, SEQ);
        check_outs("t5.f2", 1'b1, 32'h0F1E2D3C, 1'b1, 1'b0, 1'b0);

        send(3'd0, seg_tab[5]);
        send(3'd1, seg_tab[6]);
        send(3'd2, seg_tab[7]);
        #2 rst = 1'b1;
        #1 check_outs("t6.async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(32'h89ABCDEF, SEQ);
        check_outs("t6.f1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h89ABCDEF, MIX);
        check_outs("t6.f2", 1'b1, 32'h89ABCDEF, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
